// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: target side of the 6502 core memory interface.
// Decodes the NES CPU map into work RAM (2 KB mirrored below $2000), PPU
// registers (mirrored every 8 up to $3FFF) and an external port for the
// remainder. Returns registered read data with one cycle of latency.
// Optional feature macro: OAM_DMA_EN. When it is defined, a write to DMA_REG
// launches a 256-byte OAM DMA that stalls the CPU. When it is undefined,
// that write is an ordinary external write and stall is tied low.
module cpu_bus_responder #(
   parameter logic [15:0] DMA_REG  = 16'h4014,
   parameter logic [2:0]  OAM_DATA = 3'd4,
   parameter int          RAM_AW   = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       addr,
   input  logic              read,
   input  logic              write,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              stall,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   output logic              ppu_cs,
   output logic              ppu_we,
   output logic [2:0]        ppu_reg,
   output logic [7:0]        ppu_wdata,
   input  logic [7:0]        ppu_rdata,
   output logic              ext_cs,
   output logic              ext_we,
   output logic [15:0]       ext_addr,
   output logic [7:0]        ext_wdata,
   input  logic [7:0]        ext_rdata
);

   typedef enum logic [1:0] {SRC_RAM, SRC_PPU, SRC_EXT} src_e;

   // Effective bus request: the CPU in IDLE, or the DMA engine while it runs.
   logic [15:0] bus_addr;
   logic        bus_rd;
   logic        bus_wr;
   logic        dma_launch;
   logic        dma_wr;
   src_e        bus_src;

   // Read bookkeeping: which source was read last cycle and whether one was.
   logic        rd_pend;
   src_e        rd_src;
   logic [7:0]  src_rdata;

`ifdef OAM_DMA_EN
   typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RD, S_WR} state_e;

   state_e     state;
   state_e     state_nx;
   logic [7:0] page;
   logic [7:0] idx;

   // DMA state register plus the page/index counters and the stall flag.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         page  <= 8'h00;
         idx   <= 8'h00;
         stall <= 1'b0;
      end else begin
         state <= state_nx;
         if (dma_launch) begin
            page  <= wdata;
            idx   <= 8'h00;
            stall <= 1'b1;
         end
         if (state == S_WR) begin
            idx <= idx + 8'd1;
            if (idx == 8'hFF) stall <= 1'b0;
         end
      end
   end

   // Next-state logic and the bus request owned by each DMA state.
   // NOTE: every always_comb output gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      bus_addr = addr;
      bus_rd   = read;
      bus_wr   = write;
      dma_wr   = 1'b0;
      case (state)
         S_IDLE:  if (dma_launch) state_nx = S_ALIGN;
         S_ALIGN: begin
            bus_rd   = 1'b0;
            bus_wr   = 1'b0;
            state_nx = S_RD;
         end
         S_RD: begin
            bus_addr = {page, idx};
            bus_rd   = 1'b1;
            bus_wr   = 1'b0;
            state_nx = S_WR;
         end
         S_WR: begin
            bus_rd   = 1'b0;
            bus_wr   = 1'b0;
            dma_wr   = 1'b1;
            state_nx = (idx == 8'hFF) ? S_IDLE : S_RD;
         end
         default: state_nx = S_IDLE;
      endcase
   end
`else
   // Without the DMA engine the CPU always owns the bus.
   always_comb begin
      bus_addr = addr;
      bus_rd   = read;
      bus_wr   = write;
      dma_wr   = 1'b0;
   end

   assign stall = 1'b0;
`endif

   // Read data of the source selected on the previous cycle.
   always_comb begin
      case (rd_src)
         SRC_RAM: src_rdata = ram_rdata;
         SRC_PPU: src_rdata = ppu_rdata;
         default: src_rdata = ext_rdata;
      endcase
   end

   // Address decode into RAM / PPU / external selects, gated by reset and
   // the strobes; the DMA write cycle overrides the PPU port.
   always_comb begin
      ram_addr   = bus_addr[RAM_AW-1:0];
      ram_we     = 1'b0;
      ram_wdata  = wdata;
      ppu_cs     = 1'b0;
      ppu_we     = 1'b0;
      ppu_reg    = bus_addr[2:0];
      ppu_wdata  = wdata;
      ext_cs     = 1'b0;
      ext_we     = 1'b0;
      ext_addr   = bus_addr;
      ext_wdata  = wdata;
      dma_launch = 1'b0;
      bus_src    = SRC_EXT;
      if (!rst && (bus_rd || bus_wr)) begin
         if (bus_addr[15:13] == 3'b000) begin
            ram_we  = bus_wr;
            bus_src = SRC_RAM;
         end else if (bus_addr[15:14] == 2'b00) begin
            ppu_cs  = 1'b1;
            ppu_we  = bus_wr;
            bus_src = SRC_PPU;
         end else begin
`ifdef OAM_DMA_EN
            if (bus_wr && bus_addr == DMA_REG) begin
               dma_launch = 1'b1;
            end else begin
               ext_cs = 1'b1;
               ext_we = bus_wr;
            end
`else
            ext_cs = 1'b1;
            ext_we = bus_wr;
`endif
         end
      end
      if (dma_wr) begin
         ppu_cs    = 1'b1;
         ppu_we    = 1'b1;
         ppu_reg   = OAM_DATA;
         ppu_wdata = src_rdata;
      end
   end

   // Track the read in flight and load rdata one edge after the source
   // registers its data; with no read pending rdata holds (open bus).
   // NOTE: only control and data registers are reset here; the work RAM is
   // external and keeps whatever contents it powers up with.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend <= 1'b0;
         rd_src  <= SRC_EXT;
         rdata   <= 8'h00;
      end else begin
         rd_pend <= bus_rd;
         if (bus_rd) rd_src <= bus_src;
         if (rd_pend) rdata <= src_rdata;
      end
   end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed bench for cpu_bus_responder with simple
// RAM / PPU / external target models. DMA scenarios run when OAM_DMA_EN is
// defined; the plain external-write decode of $4014 runs otherwise.
module tb_cpu_bus_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic        read;
   logic        write;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        stall;
   logic [10:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = 8'h00;
   logic        ppu_cs;
   logic        ppu_we;
   logic [2:0]  ppu_reg;
   logic [7:0]  ppu_wdata;
   logic [7:0]  ppu_rdata = 8'h00;
   logic        ext_cs;
   logic        ext_we;
   logic [15:0] ext_addr;
   logic [7:0]  ext_wdata;
   logic [7:0]  ext_rdata = 8'h00;

   int checks   = 0;
   int failures = 0;

   logic [7:0] ram_mem [2048];
   logic [7:0] ppu_val = 8'h00;
   logic [7:0] ext_val = 8'h00;

   cpu_bus_responder dut (
      .clk(clk), .rst(rst), .addr(addr), .read(read), .write(write),
      .wdata(wdata), .rdata(rdata), .stall(stall),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .ppu_cs(ppu_cs), .ppu_we(ppu_we), .ppu_reg(ppu_reg),
      .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata),
      .ext_cs(ext_cs), .ext_we(ext_we), .ext_addr(ext_addr),
      .ext_wdata(ext_wdata), .ext_rdata(ext_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous work RAM: read data valid the cycle after the address.
   always @(posedge clk) begin
      ram_rdata <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
   end

   // PPU and external ports return their configured value on a read.
   always @(posedge clk) begin
      if (ppu_cs && !ppu_we) ppu_rdata <= ppu_val;
      if (ext_cs && !ext_we) ext_rdata <= ext_val;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_idle();
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      addr = a; wdata = d; write = 1'b1; read = 1'b0;
      step();
      cpu_idle();
   endtask

   task automatic test_reset();
      rst = 1'b1; addr = 16'h0000; wdata = 8'hFF; write = 1'b1; read = 1'b0;
      #2;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
      checks++; if (ppu_cs !== 1'b0) begin failures++; $display("FAIL reset_ppu_cs got=%b exp=0", ppu_cs); end
      checks++; if (ext_cs !== 1'b0) begin failures++; $display("FAIL reset_ext_cs got=%b exp=0", ext_cs); end
      cpu_idle();
      step(); step();
      rst = 1'b0;
      #1;
      checks++; if ({ram_we, ppu_cs, ext_cs} !== 3'b000) begin failures++; $display("FAIL idle_selects got=%b exp=000", {ram_we, ppu_cs, ext_cs}); end
   endtask

   task automatic test_ram();
      addr = 16'h0801; wdata = 8'h5A; write = 1'b1; #1;
      checks++; if (ram_addr !== 11'h001) begin failures++; $display("FAIL ram_wr_addr got=%h exp=001", ram_addr); end
      checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL ram_wr_we got=%b exp=1", ram_we); end
      step();
      addr = 16'h1801; write = 1'b0; read = 1'b1; #1;
      checks++; if (ram_addr !== 11'h001) begin failures++; $display("FAIL ram_rd_addr got=%h exp=001", ram_addr); end
      checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL ram_rd_we got=%b exp=0", ram_we); end
      step();
      cpu_idle();
      step();
      checks++; if (rdata !== 8'h5A) begin failures++; $display("FAIL ram_rdata got=%h exp=5A", rdata); end
   endtask

   task automatic test_ppu();
      ppu_val = 8'hC3;
      addr = 16'h3FFA; read = 1'b1; #1;
      checks++; if ({ppu_cs, ppu_we} !== 2'b10) begin failures++; $display("FAIL ppu_rd_sel got=%b exp=10", {ppu_cs, ppu_we}); end
      checks++; if (ppu_reg !== 3'd2) begin failures++; $display("FAIL ppu_rd_reg got=%0d exp=2", ppu_reg); end
      step();
      cpu_idle();
      step();
      checks++; if (rdata !== 8'hC3) begin failures++; $display("FAIL ppu_rdata got=%h exp=C3", rdata); end
      addr = 16'h2007; wdata = 8'h9E; write = 1'b1; #1;
      checks++; if ({ppu_cs, ppu_we, ppu_reg} !== 5'b11_111) begin failures++; $display("FAIL ppu_wr_sel got=%b exp=11111", {ppu_cs, ppu_we, ppu_reg}); end
      checks++; if (ppu_wdata !== 8'h9E) begin failures++; $display("FAIL ppu_wr_data got=%h exp=9E", ppu_wdata); end
      step();
      cpu_idle();
   endtask

   task automatic test_ext_read_open_bus();
      ext_val = 8'h77;
      addr = 16'h8123; read = 1'b1; #1;
      checks++; if ({ext_cs, ext_we} !== 2'b10) begin failures++; $display("FAIL ext_rd_sel got=%b exp=10", {ext_cs, ext_we}); end
      checks++; if (ext_addr !== 16'h8123) begin failures++; $display("FAIL ext_rd_addr got=%h exp=8123", ext_addr); end
      step();
      cpu_idle();
      ext_val = 8'h11;
      step();
      checks++; if (rdata !== 8'h77) begin failures++; $display("FAIL ext_rdata got=%h exp=77", rdata); end
      step(); step(); step();
      checks++; if (rdata !== 8'h77) begin failures++; $display("FAIL open_bus_hold got=%h exp=77", rdata); end
   endtask

`ifdef OAM_DMA_EN
   task automatic test_dma();
      int pulses = 0;
      for (int i = 0; i < 256; i++) cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'hA5);
      addr = 16'h4014; wdata = 8'h02; write = 1'b1; #1;
      checks++; if (ext_cs !== 1'b0) begin failures++; $display("FAIL dma_no_ext got=%b exp=0", ext_cs); end
      step();
      cpu_idle();
      for (int cyc = 1; cyc <= 520; cyc++) begin
         checks++;
         if (stall !== (cyc <= 513)) begin failures++; $display("FAIL dma_stall cyc=%0d got=%b exp=%b", cyc, stall, cyc <= 513); end
         if (ppu_we === 1'b1) begin
            checks++;
            if (cyc != 3 + 2 * pulses || ppu_reg !== 3'd4 || ppu_wdata !== (8'(pulses) ^ 8'hA5)) begin
               failures++;
               $display("FAIL dma_pulse n=%0d cyc=%0d reg=%0d data=%h exp_cyc=%0d exp_reg=4 exp_data=%h",
                        pulses, cyc, ppu_reg, ppu_wdata, 3 + 2 * pulses, 8'(pulses) ^ 8'hA5);
            end
            pulses++;
         end
         step();
      end
      checks++; if (pulses != 256) begin failures++; $display("FAIL dma_pulse_count got=%0d exp=256", pulses); end
   endtask

   task automatic test_dma_reset();
      int pulses = 0;
      int late   = 0;
      cpu_write(16'h0000, 8'h3C);
      cpu_write(16'h4014, 8'h02);
      for (int cyc = 0; cyc < 600 && pulses < 100; cyc++) begin
         if (ppu_we === 1'b1) pulses++;
         step();
      end
      checks++; if (pulses != 100) begin failures++; $display("FAIL dma_rst_reach got=%0d exp=100", pulses); end
      rst = 1'b1; #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL dma_rst_stall got=%b exp=0", stall); end
      for (int i = 0; i < 3; i++) begin
         if (ppu_we !== 1'b0) late++;
         step();
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (ppu_we !== 1'b0 || stall !== 1'b0) late++;
         step();
      end
      checks++; if (late != 0) begin failures++; $display("FAIL dma_rst_quiet got=%0d exp=0", late); end
      addr = 16'h0000; read = 1'b1; #1;
      checks++; if (ram_addr !== 11'h000) begin failures++; $display("FAIL post_rst_addr got=%h exp=000", ram_addr); end
      step();
      cpu_idle();
      step();
      checks++; if (rdata !== 8'h3C) begin failures++; $display("FAIL post_rst_rdata got=%h exp=3C", rdata); end
   endtask
`else
   task automatic test_no_dma();
      int high = 0;
      addr = 16'h4014; wdata = 8'h02; write = 1'b1; #1;
      checks++; if ({ext_cs, ext_we} !== 2'b11) begin failures++; $display("FAIL nodma_sel got=%b exp=11", {ext_cs, ext_we}); end
      checks++; if (ext_addr !== 16'h4014) begin failures++; $display("FAIL nodma_addr got=%h exp=4014", ext_addr); end
      checks++; if (ext_wdata !== 8'h02) begin failures++; $display("FAIL nodma_wdata got=%h exp=02", ext_wdata); end
      step();
      cpu_idle();
      for (int i = 0; i < 8; i++) begin
         if (stall !== 1'b0) high++;
         step();
      end
      checks++; if (high != 0) begin failures++; $display("FAIL nodma_stall got=%0d exp=0", high); end
   endtask
`endif

   initial begin
      test_reset();
      test_ram();
      test_ppu();
      test_ext_read_open_bus();
`ifdef OAM_DMA_EN
      test_dma();
      test_dma_reset();
`else
      test_no_dma();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
